// File: rtl/bfloat8_score_collector.sv
// bfloat8_score_collector
//   Collects one frame of NUM_CLASSES bfloat8 class scores from a serial
//   valid/ready stream, holds them stable on a parallel bus for an external
//   max finder, then captures the max finder's {prediction, value} and offers
//   them on a result handshake.
// Ports
//   clk, reset                    clock, asynchronous active-low reset
//   s_valid/s_data/s_last/s_ready input score stream, beat k -> slot k
//   scores                        frozen frame, slot k at [k*DATA_W +: DATA_W]
//   mf_prediction/mf_value        registered outputs of the max finder
//   res_valid/res_ready           result handshake
//   res_class/res_value           captured max-finder outputs
//   res_nomatch                   captured class equals the no-match code
//   frame_err                     sticky framing error, cleared only by reset
module bfloat8_score_collector #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned MAXF_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic [NUM_CLASSES*DATA_W-1:0] scores,
  input  logic [IDX_W-1:0]              mf_prediction,
  input  logic [DATA_W-1:0]             mf_value,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [IDX_W-1:0]              res_class,
  output logic [DATA_W-1:0]             res_value,
  output logic                          res_nomatch,
  output logic                          frame_err
);

  localparam int unsigned CNT_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned LAT_W = $clog2(MAXF_LAT + 1);
  localparam int unsigned BUS_W = NUM_CLASSES * DATA_W;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] NOMATCH   = '1;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESULT  = 2'd3
  } state_t;

  state_t             state_q,       state_d;
  logic [CNT_W-1:0]   count_q,       count_d;
  logic [LAT_W-1:0]   lat_q,         lat_d;
  logic [BUS_W-1:0]   scores_q,      scores_d;
  logic               s_ready_q,     s_ready_d;
  logic               res_valid_q,   res_valid_d;
  logic [IDX_W-1:0]   res_class_q,   res_class_d;
  logic [DATA_W-1:0]  res_value_q,   res_value_d;
  logic               res_nomatch_q, res_nomatch_d;
  logic               frame_err_q,   frame_err_d;

  logic beat_c;

  // A beat is only taken while the registered ready is high.
  assign beat_c = s_valid && s_ready_q;

  // Next-state, slot write and result capture.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    lat_d         = lat_q;
    scores_d      = scores_q;
    res_valid_d   = res_valid_q;
    res_class_d   = res_class_q;
    res_value_d   = res_value_q;
    res_nomatch_d = res_nomatch_q;
    frame_err_d   = frame_err_q;

    case (state_q)
      ST_COLLECT: begin
        if (beat_c) begin
          for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
            if (count_q == CNT_W'(k)) begin
              scores_d[k*DATA_W +: DATA_W] = s_data;
            end
          end
          if (count_q == LAST_SLOT) begin
            if (s_last) begin
              // Full frame: freeze the bus and let the max finder settle.
              state_d = ST_WAIT;
              lat_d   = LAT_W'(MAXF_LAT);
            end else begin
              // Frame overruns: discard beats until its s_last shows up.
              frame_err_d = 1'b1;
              count_d     = '0;
              state_d     = ST_DRAIN;
            end
          end else if (s_last) begin
            // Short frame: dropped, restart at slot 0.
            frame_err_d = 1'b1;
            count_d     = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (beat_c && s_last) begin
          state_d = ST_COLLECT;
        end
      end

      ST_WAIT: begin
        if (lat_q == '0) begin
          res_class_d   = mf_prediction;
          res_value_d   = mf_value;
          res_nomatch_d = (mf_prediction == NOMATCH);
          res_valid_d   = 1'b1;
          state_d       = ST_RESULT;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end

      ST_RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          count_d     = '0;
          state_d     = ST_COLLECT;
        end
      end

      default: begin
        state_d = ST_COLLECT;
        count_d = '0;
      end
    endcase

    // Ready is registered, so it follows the state being entered.
    s_ready_d = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_COLLECT;
      count_q       <= '0;
      lat_q         <= '0;
      scores_q      <= '0;
      s_ready_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_class_q   <= NOMATCH;
      res_value_q   <= '0;
      res_nomatch_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      lat_q         <= lat_d;
      scores_q      <= scores_d;
      s_ready_q     <= s_ready_d;
      res_valid_q   <= res_valid_d;
      res_class_q   <= res_class_d;
      res_value_q   <= res_value_d;
      res_nomatch_q <= res_nomatch_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign scores      = scores_q;
  assign res_valid   = res_valid_q;
  assign res_class   = res_class_q;
  assign res_value   = res_value_q;
  assign res_nomatch = res_nomatch_q;
  assign frame_err   = frame_err_q;

endmodule
